// File: rtl/gbus_pkg.sv
// Shared types and limits for the ghostbus host bridge.
package gbus_pkg;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 7;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [1:0] {
        StIdle,
        StWr,
        StRd,
        StResp
    } state_e;

endpackage

// File: rtl/gbus_host_bridge.sv
// Host command/response to ghostbus bridge: one outstanding command, all outputs registered.
module gbus_host_bridge
    import gbus_pkg::*;
#(
    parameter int unsigned AW     = 24,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_din,
    input  logic [DW-1:0] bus_dout,
    output logic          bus_we,
    output logic          busy
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("gbus_host_bridge: RD_LAT must be within 1..7");
    end

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(RD_LAT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_ready_d, rsp_valid_d, bus_we_d, busy_d;
    logic [AW-1:0]    bus_addr_d;
    logic [DW-1:0]    bus_din_d, rsp_rdata_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = 1'b0;
        rsp_valid_d = rsp_valid;
        bus_we_d    = 1'b0;
        bus_addr_d  = bus_addr;
        bus_din_d   = bus_din;
        rsp_rdata_d = rsp_rdata;
        unique case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_d = 1'b0;
                    bus_addr_d  = cmd_addr;
                    bus_din_d   = cmd_wdata;
                    if (cmd_we) begin
                        state_d  = StWr;
                        bus_we_d = 1'b1;
                    end else begin
                        state_d = StRd;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            StWr: begin
                state_d     = StIdle;
                cmd_ready_d = 1'b1;
            end
            StRd: begin
                // cnt_q equals the number of cycles bus_addr has been driven.
                if (cnt_q == LAT_CNT) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bus_dout;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            bus_we    <= 1'b0;
            busy      <= 1'b0;
            bus_addr  <= '0;
            bus_din   <= '0;
            rsp_rdata <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            bus_we    <= bus_we_d;
            busy      <= busy_d;
            bus_addr  <= bus_addr_d;
            bus_din   <= bus_din_d;
            rsp_rdata <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_gbus_host_bridge.sv
// Three bridges (RD_LAT 2, 1, 7) share stimulus; a cycle-arithmetic model checks them all.
module tb_gbus_host_bridge;

    localparam int NL  = 3;
    localparam int BIG = 32'h7fff_ffff;

    localparam int S_RDY   = 0;
    localparam int S_WE    = 1;
    localparam int S_ADDR  = 2;
    localparam int S_DIN   = 3;
    localparam int S_VALID = 4;
    localparam int S_RDATA = 5;
    localparam int S_BUSY  = 6;

    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_we, rsp_ready;
    logic [23:0] cmd_addr;
    logic [31:0] cmd_wdata;

    logic        cmd_ready_w [NL];
    logic        rsp_valid_w [NL];
    logic [31:0] rsp_rdata_w [NL];
    logic [23:0] bus_addr_w  [NL];
    logic [31:0] bus_din_w   [NL];
    logic [31:0] bus_dout_w  [NL];
    logic        bus_we_w    [NL];
    logic        busy_w      [NL];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        gbus_host_bridge #(
            .AW    (24),
            .DW    (32),
            .RD_LAT((g == 0) ? 2 : ((g == 1) ? 1 : 7))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .cmd_valid(cmd_valid),
            .cmd_ready(cmd_ready_w[g]),
            .cmd_we   (cmd_we),
            .cmd_addr (cmd_addr),
            .cmd_wdata(cmd_wdata),
            .rsp_valid(rsp_valid_w[g]),
            .rsp_ready(rsp_ready),
            .rsp_rdata(rsp_rdata_w[g]),
            .bus_addr (bus_addr_w[g]),
            .bus_din  (bus_din_w[g]),
            .bus_dout (bus_dout_w[g]),
            .bus_we   (bus_we_w[g]),
            .busy     (busy_w[g])
        );
    end

    function automatic int lat_of(int l);
        return (l == 0) ? 2 : ((l == 1) ? 1 : 7);
    endfunction

    // Ghostbus memory contents; address 0 reads 0x42.
    function automatic logic [31:0] mem(logic [23:0] a);
        return {8'h00, a} ^ 32'h42 ^ {a[15:0], 16'h0};
    endfunction

    function automatic string sig_name(int s);
        case (s)
            S_RDY:   return "cmd_ready";
            S_WE:    return "bus_we";
            S_ADDR:  return "bus_addr";
            S_DIN:   return "bus_din";
            S_VALID: return "rsp_valid";
            S_RDATA: return "rsp_rdata";
            default: return "busy";
        endcase
    endfunction

    function automatic logic [31:0] sig_val(int l, int s);
        case (s)
            S_RDY:   return 32'(cmd_ready_w[l]);
            S_WE:    return 32'(bus_we_w[l]);
            S_ADDR:  return 32'(bus_addr_w[l]);
            S_DIN:   return bus_din_w[l];
            S_VALID: return 32'(rsp_valid_w[l]);
            S_RDATA: return rsp_rdata_w[l];
            default: return 32'(busy_w[l]);
        endcase
    endfunction

    // Hand-computed expectations: checked by the compare process in the named cycle.
    typedef struct {
        int          cyc;
        int          lane;
        int          sig;
        logic [31:0] exp;
    } pin_t;
    pin_t pins[$];

    task automatic pin(int c, int l, int s, logic [31:0] e);
        pin_t p;
        p.cyc  = c;
        p.lane = l;
        p.sig  = s;
        p.exp  = e;
        pins.push_back(p);
    endtask

    int          cyc    = 0;
    bit          armed  = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          idle_from [NL];
    int          busy_from [NL];
    int          we_cyc    [NL];
    int          resp_from [NL];
    int          hs_cyc    [NL];
    bit          pend      [NL];
    logic [23:0] e_addr    [NL];
    logic [31:0] e_din     [NL];
    logic [31:0] e_rdata   [NL];

    task automatic chk(string nm, int l, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d cycle %0d: got %h expected %h", nm, l, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        bit er, ev, eb, ew;
        for (int l = 0; l < NL; l++) begin
            er = (cyc >= idle_from[l]);
            eb = (cyc >= busy_from[l]) && (cyc < idle_from[l]);
            ew = (cyc == we_cyc[l]);
            ev = pend[l] && (cyc >= resp_from[l]);
            if (armed) begin
                chk("cmd_ready", l, 32'(cmd_ready_w[l]), 32'(er));
                chk("busy", l, 32'(busy_w[l]), 32'(eb));
                chk("bus_we", l, 32'(bus_we_w[l]), 32'(ew));
                chk("rsp_valid", l, 32'(rsp_valid_w[l]), 32'(ev));
                chk("bus_addr", l, 32'(bus_addr_w[l]), 32'(e_addr[l]));
                chk("bus_din", l, bus_din_w[l], e_din[l]);
                if (ev) chk("rsp_rdata", l, rsp_rdata_w[l], e_rdata[l]);
            end
        end
        foreach (pins[i]) begin
            if (pins[i].cyc == cyc)
                chk({"pin_", sig_name(pins[i].sig)}, pins[i].lane,
                    sig_val(pins[i].lane, pins[i].sig), pins[i].exp);
        end
        for (int l = 0; l < NL; l++) begin
            er = (cyc >= idle_from[l]);
            ev = pend[l] && (cyc >= resp_from[l]);
            if (rst) begin
                idle_from[l] = cyc + 2;
                busy_from[l] = BIG;
                we_cyc[l]    = -1;
                pend[l]      = 1'b0;
                hs_cyc[l]    = cyc;
                e_addr[l]    = '0;
                e_din[l]     = '0;
                e_rdata[l]   = '0;
            end else if (armed) begin
                if (cmd_valid && er) begin
                    hs_cyc[l]    = cyc;
                    busy_from[l] = cyc + 1;
                    e_addr[l]    = cmd_addr;
                    e_din[l]     = cmd_wdata;
                    if (cmd_we) begin
                        we_cyc[l]    = cyc + 1;
                        idle_from[l] = cyc + 2;
                    end else begin
                        pend[l]      = 1'b1;
                        resp_from[l] = cyc + lat_of(l) + 1;
                        idle_from[l] = BIG;
                        e_rdata[l]   = mem(cmd_addr);
                    end
                end else if (ev && rsp_ready) begin
                    pend[l]      = 1'b0;
                    idle_from[l] = cyc + 1;
                end
            end
        end
        if (rst) armed = 1'b1;
        // Bus returns garbage until the address has been held for RD_LAT cycles.
        for (int l = 0; l < NL; l++) begin
            if (cyc - hs_cyc[l] >= lat_of(l)) bus_dout_w[l] = mem(bus_addr_w[l]);
            else bus_dout_w[l] = 32'hDEAD_0000 | 32'(cyc & 16'hffff);
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wait(int n);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        repeat (4) step();
        step();
        rst = 1'b0;
        n = cyc;
        pin(n, 0, S_RDY, 0);
        pin(n, 0, S_RDATA, 0);
        pin(n, 0, S_ADDR, 0);
        pin(n + 1, 0, S_RDY, 1);
        pin(n + 1, 2, S_RDY, 1);
        idle_wait(6);

        // Write then read with cmd_valid held high.
        n = cyc;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 24'h000100;
        cmd_wdata = 32'h0000_00A5;
        pin(n, 0, S_RDY, 1);
        pin(n + 1, 0, S_WE, 1);
        pin(n + 1, 0, S_ADDR, 32'h100);
        pin(n + 1, 0, S_DIN, 32'hA5);
        pin(n + 1, 0, S_RDY, 0);
        pin(n + 1, 0, S_BUSY, 1);
        pin(n + 2, 0, S_WE, 0);
        pin(n + 2, 0, S_RDY, 1);
        for (int k = 1; k <= 4; k++) pin(n + k, 0, S_VALID, 0);
        pin(n + 3, 0, S_RDY, 0);
        pin(n + 3, 0, S_ADDR, 0);
        pin(n + 5, 0, S_VALID, 1);
        pin(n + 5, 0, S_RDATA, 32'h42);
        pin(n + 5, 0, S_RDY, 0);
        pin(n + 6, 0, S_VALID, 0);
        pin(n + 6, 0, S_RDY, 1);
        pin(n + 3, 1, S_VALID, 0);
        pin(n + 4, 1, S_VALID, 1);
        pin(n + 9, 2, S_VALID, 0);
        pin(n + 10, 2, S_VALID, 1);
        pin(n + 10, 2, S_RDATA, 32'h42);
        step();
        cmd_we    = 1'b0;
        cmd_addr  = 24'h000000;
        cmd_wdata = 32'hFFFF_FFFF;
        step();
        step();
        cmd_valid = 1'b0;
        cmd_addr  = 24'hABCDEF;
        idle_wait(14);

        // Read response held while rsp_ready stays low.
        n = cyc;
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 24'h000123;
        rsp_ready = 1'b0;
        for (int k = 3; k <= 8; k++) pin(n + k, 0, S_VALID, 1);
        for (int k = 3; k <= 7; k++) pin(n + k, 0, S_RDATA, 32'h0123_0161);
        pin(n + 7, 0, S_ADDR, 32'h123);
        pin(n + 8, 0, S_RDY, 0);
        pin(n + 9, 0, S_VALID, 0);
        pin(n + 9, 0, S_RDY, 1);
        step();
        cmd_we   = 1'b1;
        cmd_addr = 24'h555555;
        repeat (6) step();
        step();
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        idle_wait(12);

        // Reset pulse while a read is in flight.
        n = cyc;
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 24'h000200;
        pin(n + 1, 0, S_BUSY, 1);
        pin(n + 2, 0, S_RDY, 0);
        pin(n + 2, 0, S_BUSY, 0);
        pin(n + 2, 0, S_ADDR, 0);
        pin(n + 3, 0, S_RDY, 1);
        for (int k = 2; k <= 10; k++) begin
            pin(n + k, 0, S_VALID, 0);
            pin(n + k, 0, S_WE, 0);
        end
        step();
        cmd_valid = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        idle_wait(12);

        repeat (3000) begin
            step();
            rst       = ($urandom_range(0, 199) == 0);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_we    = 1'($urandom_range(0, 1));
            cmd_addr  = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
            cmd_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        step();
        rst = 1'b0;
        idle_wait(12);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gbus_host_bridge.md
GBUS_HOST_BRIDGE -- requirements
Module: gbus_host_bridge

Interface
REQ-001 Parameters SHALL be, one per line:
  AW  24  bus address width
  DW  32  bus data width
  RD_LAT  2  cycles from first bus_addr cycle to valid bus_dout; legal 1..7
REQ-002 Ports SHALL be, one per line:
  clk  in  1  sole clock, all logic on rising edge
  rst  in  1  synchronous, active-high reset
  cmd_valid  in  1  host command present
  cmd_ready  out  1  bridge accepts command this cycle
  cmd_we  in  1  1=write, 0=read
  cmd_addr  in  AW  command address
  cmd_wdata  in  DW  write data
  rsp_valid  out  1  read response present
  rsp_ready  in  1  host consumes response
  rsp_rdata  out  DW  read data
  bus_addr  out  AW  to ghostbus addr
  bus_din  out  DW  to ghostbus din
  bus_dout  in  DW  from ghostbus dout
  bus_we  out  1  ghostbus write strobe
  busy  out  1  state != IDLE
REQ-003 Clock and reset SHALL be exactly one clock (clk) and a synchronous active-high reset (rst).

Function
REQ-004 The FSM SHALL have states IDLE, WR, RD, RESP; all outputs SHALL be registered.
REQ-005 cmd_ready SHALL be 1 only in IDLE; a handshake occurs on a cycle N with cmd_valid&&cmd_ready.
REQ-006 On handshake, bus_addr<=cmd_addr and bus_din<=cmd_wdata, valid from cycle N+1 and held until the next handshake.
REQ-007 Write: state WR in cycle N+1 with bus_we=1 for exactly that one cycle; state IDLE and cmd_ready=1 in cycle N+2; no response is generated.
REQ-008 Read: state RD from cycle N+1 and bus_we=0; a 3-bit counter SHALL sample bus_dout into rsp_rdata at the edge ending cycle N+RD_LAT.
REQ-009 The bridge SHALL enter RESP with rsp_valid=1 in cycle N+RD_LAT+1.
REQ-010 rsp_valid and rsp_rdata SHALL hold stable until rsp_valid&&rsp_ready; the next cycle is IDLE with rsp_valid=0.
REQ-011 Read-to-next-command minimum: with rsp_ready tied 1, a new handshake SHALL be possible in cycle N+RD_LAT+2.
REQ-012 bus_we SHALL never assert outside WR; cmd_valid asserted outside IDLE SHALL be ignored, with no queuing.
REQ-013 cmd_addr/cmd_wdata values outside the handshake cycle SHALL NOT affect bus outputs.
REQ-014 busy SHALL equal (state != IDLE).

Reset
REQ-015 While rst=1 at an edge: state<=IDLE, cmd_ready<=0, rsp_valid<=0, bus_we<=0, busy<=0, bus_addr<=0, bus_din<=0, rsp_rdata<=0, counter<=0.
REQ-016 cmd_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-017 Reset mid-operation (WR, RD or RESP) SHALL abort the operation: no response is issued and bus_we is 0 from the next cycle.

Structure
REQ-018 Package gbus_pkg SHALL hold the FSM state typedef, RD_LAT_MIN=1, RD_LAT_MAX=7 and the counter width (3).
REQ-019 No sub-module is required; the latency counter stays inline.
REQ-020 The block SHALL elaborate-time error if RD_LAT is outside 1..7.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
  - Write addr 0x000100, data 0xA5 -> bus_we=1 for exactly one cycle (N+1) with bus_addr=0x000100 and bus_din=0xA5; no rsp_valid.
  - Read with RD_LAT=2, bus model returns 0x00000042 for addr 0x0 -> rsp_valid in N+3 with rsp_rdata=0x42.
  - Read with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable all 5 cycles; IDLE one cycle after the ready handshake.
  - Back-to-back write then read with cmd_valid held 1 -> second handshake in N+2; cmd_ready=0 during WR/RD/RESP.
  - rst pulsed during RD -> no rsp_valid ever, cmd_ready=1 the cycle after rst drops, bus_we stays 0.
  - RD_LAT=1 and RD_LAT=7 sweeps -> rsp_valid exactly in N+RD_LAT+1 for each.
